// File: rtl/dcache_miss_ctrl.sv
// Miss handler for the 4-way data cache: dirty-victim write-back burst, refill read burst, block write.
// Optional miss/write-back event counters are enabled with `define DCACHE_MISS_CNT_EN.
module dcache_miss_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int SET_WIDTH  = 512,
    parameter int BUS_WIDTH  = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_mem_access,
    input  logic                  i_hit,
    input  logic                  i_dirty,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr_wb,
    input  logic [SET_WIDTH-1:0]  i_data_block,
    output logic                  o_stall,
    output logic                  o_block_we,
    output logic [SET_WIDTH-1:0]  o_data_block,
    output logic                  o_mem_req_valid,
    output logic                  o_mem_req_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_wvalid,
    output logic [BUS_WIDTH-1:0]  o_mem_wdata,
    input  logic                  i_mem_wready,
    input  logic                  i_mem_rvalid,
    input  logic [BUS_WIDTH-1:0]  i_mem_rdata,
`ifdef DCACHE_MISS_CNT_EN
    output logic [31:0]           o_miss_count,
    output logic [31:0]           o_wb_count,
`endif
    output logic                  o_mem_rready
);

    localparam int BEATS    = SET_WIDTH / BUS_WIDTH;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFSET_W = $clog2(SET_WIDTH / 8);
    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET_W) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WB_REQ    = 3'd1,
        WB_DATA   = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_DATA = 3'd4,
        REFILL    = 3'd5
    } state_t;

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [ADDR_WIDTH-1:0] fill_addr_r;
    logic [SET_WIDTH-1:0]  wb_block_r;
    logic                  req_valid_r;
    logic                  req_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic                  wvalid_r;
    logic [BUS_WIDTH-1:0]  wdata_r;
    logic                  rready_r;
    logic                  block_we_r;
    logic [SET_WIDTH-1:0]  data_block_r;

    logic                  miss_s;
    logic [ADDR_WIDTH-1:0] fill_addr_s;

    assign miss_s      = i_mem_access & ~i_hit;
    assign fill_addr_s = i_addr & OFFSET_MASK;

    assign o_block_we      = block_we_r;
    assign o_data_block    = data_block_r;
    assign o_mem_req_valid = req_valid_r;
    assign o_mem_req_we    = req_we_r;
    assign o_mem_addr      = mem_addr_r;
    assign o_mem_wvalid    = wvalid_r;
    assign o_mem_wdata     = wdata_r;
    assign o_mem_rready    = rready_r;

    // Stall is raised in the miss cycle itself and held until the FSM is back in IDLE.
    always_comb begin
        o_stall = 1'b1;
        if (state_r == IDLE) begin
            o_stall = miss_s;
        end else begin
            o_stall = 1'b1;
        end
    end

    // Miss FSM; every memory-side output is a register set on the transition into its state.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            fill_addr_r  <= '0;
            wb_block_r   <= '0;
            req_valid_r  <= 1'b0;
            req_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            wvalid_r     <= 1'b0;
            wdata_r      <= '0;
            rready_r     <= 1'b0;
            block_we_r   <= 1'b0;
            data_block_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    block_we_r <= 1'b0;
                    if (miss_s) begin
                        fill_addr_r <= fill_addr_s;
                        req_valid_r <= 1'b1;
                        if (i_dirty) begin
                            wb_block_r <= i_data_block;
                            req_we_r   <= 1'b1;
                            mem_addr_r <= i_addr_wb;
                            state_r    <= WB_REQ;
                        end else begin
                            req_we_r   <= 1'b0;
                            mem_addr_r <= fill_addr_s;
                            state_r    <= FILL_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    if (i_mem_req_ready) begin
                        req_valid_r <= 1'b0;
                        req_we_r    <= 1'b0;
                        wvalid_r    <= 1'b1;
                        wdata_r     <= wb_block_r[BUS_WIDTH-1:0];
                        cnt_r       <= '0;
                        state_r     <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    if (i_mem_wready) begin
                        if (cnt_r == LAST_BEAT) begin
                            wvalid_r    <= 1'b0;
                            wdata_r     <= '0;
                            req_valid_r <= 1'b1;
                            req_we_r    <= 1'b0;
                            mem_addr_r  <= fill_addr_r;
                            cnt_r       <= '0;
                            state_r     <= FILL_REQ;
                        end else begin
                            // Preload the next beat so wdata is registered and stable while waiting.
                            wdata_r <= wb_block_r[(int'(cnt_r) + 1) * BUS_WIDTH +: BUS_WIDTH];
                            cnt_r   <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                FILL_REQ: begin
                    if (i_mem_req_ready) begin
                        req_valid_r <= 1'b0;
                        rready_r    <= 1'b1;
                        cnt_r       <= '0;
                        state_r     <= FILL_DATA;
                    end
                end
                FILL_DATA: begin
                    if (i_mem_rvalid) begin
                        data_block_r[int'(cnt_r) * BUS_WIDTH +: BUS_WIDTH] <= i_mem_rdata;
                        if (cnt_r == LAST_BEAT) begin
                            rready_r   <= 1'b0;
                            block_we_r <= 1'b1;
                            cnt_r      <= '0;
                            state_r    <= REFILL;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                REFILL: begin
                    block_we_r <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    req_valid_r <= 1'b0;
                    req_we_r    <= 1'b0;
                    wvalid_r    <= 1'b0;
                    rready_r    <= 1'b0;
                    block_we_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_MISS_CNT_EN
    logic [31:0] miss_count_r;
    logic [31:0] wb_count_r;

    assign o_miss_count = miss_count_r;
    assign o_wb_count   = wb_count_r;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            miss_count_r <= 32'd0;
            wb_count_r   <= 32'd0;
        end else begin
            if ((state_r == IDLE) && miss_s) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
            if ((state_r == WB_REQ) && i_mem_req_ready) begin
                wb_count_r <= wb_count_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed self-checking bench for dcache_miss_ctrl: clean/dirty misses, backpressure, read gaps, reset mid-burst, hits.
module tb_dcache_miss_ctrl;

    logic         i_clk = 1'b0;
    logic         i_arst;
    logic         i_mem_access, i_hit, i_dirty;
    logic [63:0]  i_addr, i_addr_wb;
    logic [511:0] i_data_block;
    logic         o_stall, o_block_we;
    logic [511:0] o_data_block;
    logic         o_mem_req_valid, o_mem_req_we;
    logic [63:0]  o_mem_addr;
    logic         i_mem_req_ready;
    logic         o_mem_wvalid;
    logic [63:0]  o_mem_wdata;
    logic         i_mem_wready, i_mem_rvalid;
    logic [63:0]  i_mem_rdata;
    logic         o_mem_rready;
`ifdef DCACHE_MISS_CNT_EN
    logic [31:0]  o_miss_count, o_wb_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [511:0] wb_blk, wb_blk2, fill_blk;

    always #5 i_clk = ~i_clk;

    dcache_miss_ctrl dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_mem_access(i_mem_access), .i_hit(i_hit), .i_dirty(i_dirty),
        .i_addr(i_addr), .i_addr_wb(i_addr_wb), .i_data_block(i_data_block),
        .o_stall(o_stall), .o_block_we(o_block_we), .o_data_block(o_data_block),
        .o_mem_req_valid(o_mem_req_valid), .o_mem_req_we(o_mem_req_we), .o_mem_addr(o_mem_addr),
        .i_mem_req_ready(i_mem_req_ready),
        .o_mem_wvalid(o_mem_wvalid), .o_mem_wdata(o_mem_wdata), .i_mem_wready(i_mem_wready),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
`ifdef DCACHE_MISS_CNT_EN
        .o_miss_count(o_miss_count), .o_wb_count(o_wb_count),
`endif
        .o_mem_rready(o_mem_rready)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " req_valid"}, 512'(o_mem_req_valid), 512'd0);
        chk({tag, " wvalid"},    512'(o_mem_wvalid),    512'd0);
        chk({tag, " rready"},    512'(o_mem_rready),    512'd0);
        chk({tag, " block_we"},  512'(o_block_we),      512'd0);
    endtask

    // Write burst; optionally toggles wready every other cycle. Checks every presented beat.
    task automatic write_burst(input logic [511:0] blk, input bit toggle);
        int beats = 0;
        int c = 0;
        while (beats < 8 && c < 64) begin
            i_mem_wready = toggle ? c[0] : 1'b1;
            #1;
            chk("wvalid", 512'(o_mem_wvalid), 512'd1);
            chk("wdata", 512'(o_mem_wdata), 512'(blk[beats*64 +: 64]));
            if (i_mem_wready) beats++;
            tick();
            c++;
        end
        i_mem_wready = 1'b0;
        chk("wbeats", 512'(beats), 512'd8);
        chk("wvalid_after", 512'(o_mem_wvalid), 512'd0);
    endtask

    // Expects FILL_REQ now; runs a read burst with 'gap' idle cycles before every beat, then the refill.
    task automatic fill(input logic [63:0] addr_exp, input logic [511:0] blk, input int gap);
        chk("fill req_valid", 512'(o_mem_req_valid), 512'd1);
        chk("fill req_we",    512'(o_mem_req_we),    512'd0);
        chk("fill addr",      512'(o_mem_addr),      512'(addr_exp));
        i_mem_req_ready = 1'b1;
        tick();
        chk("fill rready", 512'(o_mem_rready), 512'd1);
        chk("fill req_drop", 512'(o_mem_req_valid), 512'd0);
        for (int b = 0; b < 8; b++) begin
            for (int g = 0; g < gap; g++) begin
                i_mem_rvalid = 1'b0;
                tick();
                chk("gap block_we", 512'(o_block_we), 512'd0);
            end
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = blk[b*64 +: 64];
            tick();
            if (b < 7) chk("early block_we", 512'(o_block_we), 512'd0);
        end
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        chk("refill block_we", 512'(o_block_we), 512'd1);
        chk("refill block",    o_data_block, blk);
        chk("refill stall",    512'(o_stall), 512'd1);
        chk("refill rready",   512'(o_mem_rready), 512'd0);
        i_mem_access = 1'b1;
        i_hit        = 1'b1;
        tick();
        chk("post block_we", 512'(o_block_we), 512'd0);
        chk("post stall",    512'(o_stall), 512'd0);
        chk("post block",    o_data_block, blk);
        i_mem_access = 1'b0;
        i_hit        = 1'b0;
    endtask

    initial begin
        i_arst = 1'b1; i_mem_access = 1'b0; i_hit = 1'b0; i_dirty = 1'b0;
        i_addr = 64'd0; i_addr_wb = 64'd0; i_data_block = 512'd0;
        i_mem_req_ready = 1'b0; i_mem_wready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 64'd0;
        for (int b = 0; b < 8; b++) begin
            wb_blk[b*64 +: 64]  = 64'hA0 + 64'(b);
            wb_blk2[b*64 +: 64] = 64'hC0 + 64'(b);
        end
        tick(); tick();
        chk_idle_outputs("reset");
        chk("reset stall", 512'(o_stall), 512'd0);
        chk("reset block", o_data_block, 512'd0);
        chk("reset addr",  512'(o_mem_addr), 512'd0);
        i_arst = 1'b0;
        tick();

        // Clean miss, memory ready immediately, beats 0..7
        i_mem_access = 1'b1; i_hit = 1'b0; i_dirty = 1'b0; i_addr = 64'h1234_5678;
        i_mem_req_ready = 1'b1;
        #1;
        chk("miss comb stall", 512'(o_stall), 512'd1);
        tick();
        i_mem_access = 1'b0; i_addr = 64'hFFFF_FFFF;
        chk("clean stall", 512'(o_stall), 512'd1);
        for (int b = 0; b < 8; b++) fill_blk[b*64 +: 64] = 64'(b);
        fill(64'h1234_5640, fill_blk, 0);
        chk("clean lo beat", 512'(o_data_block[63:0]), 512'd0);
        chk("clean hi beat", 512'(o_data_block[511:448]), 512'd7);

        // Dirty miss with request backpressure, toggled wready, read gaps of 3
        i_mem_req_ready = 1'b0;
        i_mem_access = 1'b1; i_hit = 1'b0; i_dirty = 1'b1;
        i_addr = 64'h0000_0000_0BAD_F00D; i_addr_wb = 64'h8000_0040; i_data_block = wb_blk;
        tick();
        i_mem_access = 1'b0; i_dirty = 1'b0;
        i_addr_wb = 64'h1111_1111; i_data_block = {8{64'h5A5A}};
        i_mem_rvalid = 1'b1; i_mem_rdata = 64'hBAD0_BAD0;
        for (int c = 0; c < 5; c++) begin
            chk("wbreq valid", 512'(o_mem_req_valid), 512'd1);
            chk("wbreq we",    512'(o_mem_req_we),    512'd1);
            chk("wbreq addr",  512'(o_mem_addr),      512'(64'h8000_0040));
            chk("wbreq stall", 512'(o_stall),         512'd1);
            tick();
        end
        i_mem_rvalid = 1'b0;
        i_mem_req_ready = 1'b1;
        tick();
        chk("wb req_drop", 512'(o_mem_req_valid), 512'd0);
        write_burst(wb_blk, 1'b1);
        for (int b = 0; b < 8; b++) fill_blk[b*64 +: 64] = 64'hB0 + 64'(b);
        fill(64'h0BAD_F000, fill_blk, 3);

        // Hit traffic
        for (int c = 0; c < 10; c++) begin
            i_mem_access = 1'b1; i_hit = 1'b1; i_dirty = c[0];
            #1;
            chk("hit stall", 512'(o_stall), 512'd0);
            tick();
            chk_idle_outputs("hit");
        end
        i_mem_access = 1'b0; i_hit = 1'b0; i_dirty = 1'b0;
`ifdef DCACHE_MISS_CNT_EN
        chk("miss_count", 512'(o_miss_count), 512'd2);
        chk("wb_count",   512'(o_wb_count),   512'd1);
`endif

        // Reset during write-back beat 3
        i_mem_access = 1'b1; i_dirty = 1'b1; i_addr = 64'h7777_7777; i_addr_wb = 64'h8000_0040;
        i_data_block = wb_blk; i_mem_req_ready = 1'b1;
        tick();
        i_mem_access = 1'b0; i_dirty = 1'b0;
        tick();
        i_mem_wready = 1'b1;
        tick(); tick(); tick();
        chk("beat3 wdata", 512'(o_mem_wdata), 512'(64'hA3));
        i_mem_wready = 1'b0;
        i_arst = 1'b1;
        #1;
        chk_idle_outputs("arst");
        chk("arst wdata", 512'(o_mem_wdata), 512'd0);
        chk("arst addr",  512'(o_mem_addr),  512'd0);
        chk("arst block", o_data_block,      512'd0);
        chk("arst stall", 512'(o_stall),     512'd0);
        tick();
        i_arst = 1'b0;
        tick();
        chk_idle_outputs("post arst");

        // Fresh dirty miss restarts at beat 0
        i_mem_access = 1'b1; i_dirty = 1'b1; i_addr = 64'h5555_5555; i_addr_wb = 64'h8000_0080;
        i_data_block = wb_blk2;
        tick();
        i_mem_access = 1'b0; i_dirty = 1'b0;
        chk("restart addr", 512'(o_mem_addr), 512'(64'h8000_0080));
        tick();
        chk("restart beat0", 512'(o_mem_wdata), 512'(64'hC0));
        write_burst(wb_blk2, 1'b0);
        for (int b = 0; b < 8; b++) fill_blk[b*64 +: 64] = 64'hD0 + 64'(b);
        fill(64'h5555_5540, fill_blk, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
Miss-handling controller directly downstream of the 4-way data cache. On a lookup miss it writes back the dirty victim block, then fetches the missing block from the memory bus as BUS_WIDTH-wide beats. It assembles the beats into a full block and drives the cache's block-write strobe. Stall to the core is held until the refilled line is written into the cache.

Parameters:
ADDR_WIDTH, 64, byte address width
SET_WIDTH, 512, cache block width in bits
BUS_WIDTH, 64, memory data beat width; SET_WIDTH must be an integer multiple (BEATS = SET_WIDTH/BUS_WIDTH = 8)

Ports:
i_clk  in  1  clock
i_arst  in  1  reset, asynchronous, active-high
i_mem_access  in  1  core load/store lookup valid this cycle
i_hit  in  1  cache hit for current lookup
i_dirty  in  1  victim (PLRU way) dirty
i_addr  in  ADDR_WIDTH  core request address
i_addr_wb  in  ADDR_WIDTH  victim write-back address from cache
i_data_block  in  SET_WIDTH  victim block from cache
o_stall  out  1  hold core pipeline
o_block_we  out  1  write refilled block into cache (one-cycle pulse)
o_data_block  out  SET_WIDTH  assembled refill block
o_mem_req_valid  out  1  memory burst request valid
o_mem_req_we  out  1  1 = write burst, 0 = read burst
o_mem_addr  out  ADDR_WIDTH  block-aligned burst address
i_mem_req_ready  in  1  memory accepts request
o_mem_wvalid  out  1  write beat valid
o_mem_wdata  out  BUS_WIDTH  write beat data
i_mem_wready  in  1  memory accepts write beat
i_mem_rvalid  in  1  read beat valid
i_mem_rdata  in  BUS_WIDTH  read beat data
o_mem_rready  out  1  controller accepts read beat

Behaviour:
- States: IDLE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA, REFILL.
- Reset: state IDLE, beat counter 0, all outputs 0, o_data_block 0, latched addresses/blocks 0. Reset mid-burst aborts immediately to IDLE; no further beats are driven.
- IDLE, miss (i_mem_access & ~i_hit):
  - Latch fill address = i_addr with low log2(SET_WIDTH/8) bits cleared.
  - If i_dirty: also latch i_addr_wb and i_data_block, go WB_REQ. Otherwise go FILL_REQ.
- IDLE, otherwise: stay.
- o_stall = (i_mem_access & ~i_hit) in IDLE, or 1 in every non-IDLE state. It is combinational in IDLE, so it is asserted in the miss cycle itself.
- WB_REQ: o_mem_req_valid=1, o_mem_req_we=1, o_mem_addr=latched wb address.
  - On valid&ready go WB_DATA, counter=0.
  - Valid/addr are held stable until ready.
- WB_DATA: o_mem_wvalid=1, o_mem_wdata = latched block[cnt*BUS_WIDTH +: BUS_WIDTH], beat 0 = LSBs.
  - Counter advances only on wvalid&wready.
  - After beat BEATS-1 is accepted, go FILL_REQ.
- FILL_REQ: o_mem_req_valid=1, o_mem_req_we=0, o_mem_addr=latched fill address. On ready go FILL_DATA, counter=0.
- FILL_DATA: o_mem_rready=1.
  - Each rvalid beat is stored to o_data_block[cnt*BUS_WIDTH +: BUS_WIDTH].
  - After beat BEATS-1 is accepted, go REFILL.
  - rvalid in any other state is ignored.
- REFILL: o_block_we=1 for exactly one cycle, o_data_block stable; next state IDLE.
  - The cache re-evaluates the lookup the following cycle and hits; o_stall then drops.
- Counter width is clog2(BEATS) and never wraps mid-burst; last-beat detection is cnt==BEATS-1 with the handshake.
- Request handshake and beat handshake never occur in the same cycle.
- Inputs i_addr/i_dirty/i_data_block are sampled only in IDLE; changes during a miss are ignored.

Optional Feature:
DCACHE_MISS_CNT_EN
- Defined: adds outputs o_miss_count[31:0] and o_wb_count[31:0].
  - o_miss_count increments on each IDLE→miss transition.
  - o_wb_count increments on each WB_REQ acceptance.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Clean miss: i_addr=0x1234_5678, i_dirty=0, memory ready immediately, rdata beats 0x0..0x7 → o_mem_addr=0x1234_5640 read, o_block_we pulse in the cycle after beat 7, o_data_block[63:0]=0 and [511:448]=7, o_stall low 1 cycle later once hit.
- Dirty miss: i_addr_wb=0x8000_0040, i_data_block beats 0xA0..0xA7 → write burst to 0x8000_0040 with wdata order A0..A7, then read burst, single o_block_we.
- Backpressure: i_mem_req_ready low 5 cycles, wready toggling every other cycle → request and wdata held stable, exactly 8 write beats, no duplicated/skipped beat.
- Read stalls: i_mem_rvalid gaps of 3 cycles between beats → block assembled correctly, o_block_we only after 8th beat.
- Reset mid-burst: assert i_arst during WB_DATA beat 3 → all outputs 0, state IDLE; next miss starts fresh burst at beat 0.
- Hit traffic: 10 consecutive hits → no memory request, o_stall=0, o_block_we=0; with DCACHE_MISS_CNT_EN, o_miss_count=2 after both miss tests.
